// File: rtl/data_mem_resp.sv
// Data-memory responder for the MIPS MEM stage: word-organised RAM served after
// WAIT_CYCLES stall cycles, with misaligned / out-of-range fault reporting.
module data_mem_resp #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] adr,
  input  logic [31:0] write_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        err
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state, state_next;
  logic [3:0]  cnt;
  logic [31:0] lat_adr;
  logic [31:0] lat_wdata;
  logic        lat_write;
  logic [31:0] mem [2**ADDR_W];

  logic              req;
  logic              in_wait;
  logic [31:0]       sel_adr;
  logic [31:0]       sel_wdata;
  logic              sel_write;
  logic [ADDR_W-1:0] idx;
  logic              fault;
  logic              complete;
  logic              do_write;

  // In WAIT every decision comes from the latched request; live inputs are ignored.
  assign req       = mem_read | mem_write;
  assign in_wait   = (state == S_WAIT);
  assign sel_adr   = in_wait ? lat_adr   : adr;
  assign sel_wdata = in_wait ? lat_wdata : write_data;
  assign sel_write = in_wait ? lat_write : mem_write;
  assign idx       = sel_adr[ADDR_W+1:2];
  assign fault     = (|sel_adr[1:0]) | (|sel_adr[31:ADDR_W+2]);
  assign complete  = !rst && (in_wait ? (cnt == 4'd0) : (req && WAIT_CYCLES == 0));
  assign do_write  = complete && sel_write && !fault;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (req && WAIT_CYCLES > 0) state_next = S_WAIT;
      S_WAIT: if (cnt == 4'd0)            state_next = S_IDLE;
      default:                            state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall     = 1'b0;
    read_data = 32'd0;
    err       = 1'b0;
    if (!rst) begin
      stall = in_wait ? (cnt != 4'd0) : (req && WAIT_CYCLES > 0);
      if (complete) begin
        read_data = fault ? 32'd0 : mem[idx];
        err       = fault;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      lat_adr   <= 32'd0;
      lat_wdata <= 32'd0;
      lat_write <= 1'b0;
    end else if (state == S_IDLE && req) begin
      cnt       <= CNT_INIT;
      lat_adr   <= adr;
      lat_wdata <= write_data;
      lat_write <= mem_write;
    end else if (in_wait && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // NOTE: the RAM is deliberately a flop array with a full clear on reset,
  // because loads after reset must observe zero in every word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= 32'd0;
    end else if (do_write) begin
      mem[idx] <= sel_wdata;
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: cycle-by-cycle vector table against a WAIT_CYCLES=2
// instance, plus hand sequences for reset mid-access and a WAIT_CYCLES=0 instance.
module tb_data_mem_resp;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] adr2, wdata2, rdata2;
  logic        rd2, wr2, stall2, err2;
  logic [31:0] adr0, wdata0, rdata0;
  logic        rd0, wr0, stall0, err0;

  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst(rst), .adr(adr2), .write_data(wdata2),
    .mem_read(rd2), .mem_write(wr2),
    .read_data(rdata2), .stall(stall2), .err(err2)
  );

  data_mem_resp #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .adr(adr0), .write_data(wdata0),
    .mem_read(rd0), .mem_write(wr0),
    .read_data(rdata0), .stall(stall0), .err(err0)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive2(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    rd2 = rd; wr2 = wr; adr2 = a; wdata2 = d;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One full 3-cycle access on the WAIT_CYCLES=2 instance, checked in every cycle.
  task automatic access2(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input logic exp_err);
    drive2(rd, wr, a, d);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check($sformatf("%s stall c%0d", name, c), {31'd0, stall2}, 32'd1);
      check($sformatf("%s err c%0d", name, c), {31'd0, err2}, 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check({name, " stall done"}, {31'd0, stall2}, 32'd0);
    check({name, " rdata"}, rdata2, exp_rdata);
    check({name, " err"}, {31'd0, err2}, {31'd0, exp_err});
    next_cycle();
    drive2(1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  initial begin
    // rd, wr, adr, wdata, stall, rdata, err -- one row per clock cycle.
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h40,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h40,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h40,       32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h10,       32'hDEADBEEF, 1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 1'b0});
    // store to 0x20, then address/data change while stalled
    vecs.push_back('{1'b0, 1'b1, 32'h20,       32'h12345678, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h24,       32'h1,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h24,       32'h1,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h20,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h20,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h20,       32'h0,        1'b0, 32'h12345678, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h24,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h24,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h24,       32'h0,        1'b0, 32'h0,        1'b0});
    // misaligned store to 0x13: err for exactly the completion cycle
    vecs.push_back('{1'b0, 1'b1, 32'h13,       32'hFF,       1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h13,       32'hFF,       1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h13,       32'hFF,       1'b0, 32'h0,        1'b1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF, 1'b0});
    // out-of-range load
    vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h00010000, 32'h0,        1'b0, 32'h0,        1'b1});
    // 0x30 <- 7, then read+write of 5 returns old 7, then load returns 5
    vecs.push_back('{1'b0, 1'b1, 32'h30,       32'h7,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h30,       32'h7,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b0, 1'b1, 32'h30,       32'h7,        1'b0, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h30,       32'h5,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h30,       32'h5,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b1, 32'h30,       32'h5,        1'b0, 32'h7,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h30,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h30,       32'h0,        1'b1, 32'h0,        1'b0});
    vecs.push_back('{1'b1, 1'b0, 32'h30,       32'h0,        1'b0, 32'h5,        1'b0});

    // Reset with live requests present: outputs must still be forced to 0.
    rst = 1'b1;
    drive2(1'b1, 1'b0, 32'h13, 32'h0);
    rd0 = 1'b1; wr0 = 1'b0; adr0 = 32'h13; wdata0 = 32'h0;
    repeat (2) next_cycle();
    @(negedge clk);
    check("rst stall2", {31'd0, stall2}, 32'd0);
    check("rst rdata2", rdata2, 32'd0);
    check("rst err0", {31'd0, err0}, 32'd0);
    check("rst rdata0", rdata0, 32'd0);
    next_cycle();
    rst = 1'b0;
    drive2(1'b0, 1'b0, 32'd0, 32'd0);
    rd0 = 1'b0; adr0 = 32'd0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive2(vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].wdata);
      @(negedge clk);
      check($sformatf("v%0d stall", i), {31'd0, stall2}, {31'd0, vecs[i].exp_stall});
      check($sformatf("v%0d rdata", i), rdata2, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), {31'd0, err2}, {31'd0, vecs[i].exp_err});
      check($sformatf("v%0d stall0 idle", i), {31'd0, stall0}, 32'd0);
      next_cycle();
    end

    // Reset asserted in the first WAIT cycle of a store to 0x40.
    drive2(1'b0, 1'b1, 32'h40, 32'hAA);
    @(negedge clk);
    check("midrst stall N", {31'd0, stall2}, 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst stall in rst", {31'd0, stall2}, 32'd0);
    check("midrst err in rst", {31'd0, err2}, 32'd0);
    next_cycle();
    rst = 1'b0;
    drive2(1'b0, 1'b0, 32'd0, 32'd0);
    @(negedge clk);
    check("midrst stall after", {31'd0, stall2}, 32'd0);
    next_cycle();
    access2("midrst load40", 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    access2("ramclr load10", 1'b1, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    // WAIT_CYCLES = 0: same-cycle completion, no stall.
    rd0 = 1'b0; wr0 = 1'b1; adr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    @(negedge clk);
    check("w0 store stall", {31'd0, stall0}, 32'd0);
    check("w0 store err", {31'd0, err0}, 32'd0);
    next_cycle();
    rd0 = 1'b1; wr0 = 1'b0; adr0 = 32'h10; wdata0 = 32'h0;
    @(negedge clk);
    check("w0 load stall", {31'd0, stall0}, 32'd0);
    check("w0 load rdata", rdata0, 32'hDEADBEEF);
    next_cycle();
    adr0 = 32'h11;
    @(negedge clk);
    check("w0 misaligned err", {31'd0, err0}, 32'd1);
    check("w0 misaligned rdata", rdata0, 32'd0);
    next_cycle();
    rd0 = 1'b0; adr0 = 32'h0;
    @(negedge clk);
    check("w0 idle err", {31'd0, err0}, 32'd0);
    check("w0 idle rdata", rdata0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
